divider_reconstruct_seq: RTL

//  Sequential inverse of the 16/8 array divider: takes a divider result (q, r), the divisor d and
//  the original dividend n_ref, rebuilds n_rec = q*d + r with a shift-add multiplier, and reports
//  |n_ref - n_rec| as the error distance. Sits behind exact/approximate divider rows in the

---
 rtl/divider_reconstruct_seq_if.sv | 37 +++
 rtl/divider_reconstruct_seq.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/divider_reconstruct_seq_if.sv
// rtl/divider_reconstruct_seq_if.sv - request/result/statistics bundle for the divider reconstructor
interface divider_reconstruct_seq_if #(
  parameter int QW = 8,
  parameter int DW = 8,
  parameter int NW = 16,
  parameter int CW = 32,
  parameter int SW = 40
) ();
  logic          in_valid;
  logic          in_ready;
  logic [QW-1:0] q;
  logic [DW-1:0] d;
  logic [DW-1:0] r;
  logic [NW-1:0] n_ref;
  logic          out_valid;
  logic          out_ready;
  logic [NW:0]   n_rec;
  logic [NW:0]   err;
  logic          match;
  logic          div_zero;
  logic          stat_clr;
  logic [CW-1:0] stat_cnt;
  logic [SW-1:0] stat_err_sum;
  logic [NW:0]   stat_err_max;

  modport master (
    output in_valid, q, d, r, n_ref, out_ready, stat_clr,
    input  in_ready, out_valid, n_rec, err, match, div_zero,
           stat_cnt, stat_err_sum, stat_err_max
  );

  modport slave (
    input  in_valid, q, d, r, n_ref, out_ready, stat_clr,
    output in_ready, out_valid, n_rec, err, match, div_zero,
           stat_cnt, stat_err_sum, stat_err_max
  );
endinterface

// File: rtl/divider_reconstruct_seq.sv
// rtl/divider_reconstruct_seq.sv - rebuilds q*d+r with a shift-add multiplier and tracks error stats
module divider_reconstruct_seq #(
  parameter int QW = 8,
  parameter int DW = 8,
  parameter int NW = 16,
  parameter int CW = 32,
  parameter int SW = 40
) (
  input  logic                   clk,
  input  logic                   rst_n,
  divider_reconstruct_seq_if.slave bus
);
  localparam int CNTW = $clog2(QW + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIFF, DONE} state_t;

  state_t          state_q, state_d;
  logic [NW:0]     acc_q, acc_d;
  logic [NW:0]     mcand_q, mcand_d;
  logic [QW-1:0]   mplier_q, mplier_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [NW-1:0]   nref_q, nref_d;
  logic            div_zero_q, div_zero_d;
  logic [NW:0]     n_rec_q, n_rec_d;
  logic [NW:0]     err_q, err_d;
  logic            match_q, match_d;
  logic            out_valid_q, out_valid_d;
  logic [CW-1:0]   stat_cnt_q, stat_cnt_d;
  logic [SW-1:0]   stat_sum_q, stat_sum_d;
  logic [NW:0]     stat_max_q, stat_max_d;

  logic            hs;
  logic [NW:0]     nref_ext;
  logic [NW:0]     diff_c;
  logic [SW:0]     sum_ext;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      nref_q      <= '0;
      div_zero_q  <= 1'b0;
      n_rec_q     <= '0;
      err_q       <= '0;
      match_q     <= 1'b0;
      out_valid_q <= 1'b0;
      stat_cnt_q  <= '0;
      stat_sum_q  <= '0;
      stat_max_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      nref_q      <= nref_d;
      div_zero_q  <= div_zero_d;
      n_rec_q     <= n_rec_d;
      err_q       <= err_d;
      match_q     <= match_d;
      out_valid_q <= out_valid_d;
      stat_cnt_q  <= stat_cnt_d;
      stat_sum_q  <= stat_sum_d;
      stat_max_q  <= stat_max_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    nref_d      = nref_q;
    div_zero_d  = div_zero_q;
    n_rec_d     = n_rec_q;
    err_d       = err_q;
    match_d     = match_q;
    out_valid_d = out_valid_q;
    stat_cnt_d  = stat_cnt_q;
    stat_sum_d  = stat_sum_q;
    stat_max_d  = stat_max_q;
    hs          = 1'b0;
    nref_ext    = (NW+1)'(nref_q);
    diff_c      = (nref_ext >= acc_q) ? (nref_ext - acc_q) : (acc_q - nref_ext);
    sum_ext     = {1'b0, stat_sum_q} + (SW+1)'(err_q);

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          acc_d      = (NW+1)'(bus.r);
          mcand_d    = (NW+1)'(bus.d);
          mplier_d   = bus.q;
          cnt_d      = '0;
          nref_d     = bus.n_ref;
          div_zero_d = (bus.d == '0);
          state_d    = MUL;
        end
      end
      MUL: begin
        // Fixed QW iterations even when mplier empties early, so latency never varies.
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNTW'(QW - 1)) state_d = DIFF;
      end
      DIFF: begin
        n_rec_d     = acc_q;
        err_d       = diff_c;
        match_d     = (diff_c == '0);
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          hs          = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A clear in the same cycle as a handshake wins and drops that transaction.
    if (bus.stat_clr) begin
      stat_cnt_d = '0;
      stat_sum_d = '0;
      stat_max_d = '0;
    end else if (hs) begin
      if (stat_cnt_q != '1) stat_cnt_d = stat_cnt_q + 1'b1;
      stat_sum_d = sum_ext[SW] ? '1 : sum_ext[SW-1:0];
      if (err_q > stat_max_q) stat_max_d = err_q;
    end
  end

  assign bus.in_ready     = (state_q == IDLE);
  assign bus.out_valid    = out_valid_q;
  assign bus.n_rec        = n_rec_q;
  assign bus.err          = err_q;
  assign bus.match        = match_q;
  assign bus.div_zero     = div_zero_q;
  assign bus.stat_cnt     = stat_cnt_q;
  assign bus.stat_err_sum = stat_sum_q;
  assign bus.stat_err_max = stat_max_q;
endmodule
